lfsr_seq_checker: RTL and testbench

Receive-side checker for the LFSR pseudo-random sequences produced by the cache-replacement LFSR generator. It samples a WIDTH-bit LFSR state stream, self-synchronises by seeding its own predictor from the incoming data, and declares lock after a run of correct predictions. Once locked, it flags and counts mismatches. It drops lock after repeated consecutive misses. It sits beside the generator as a built-in self-check and bring-up monitor.

---
 rtl/lfsr_seq_checker.sv | 145 ++++++++++++++
 tb/tb_lfsr_seq_checker.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_seq_checker.sv
// Receive-side checker for Fibonacci LFSR state streams. It seeds itself from the
// incoming samples, declares lock after LOCK_CNT correct predictions, and then
// counts mismatches. Optional macro LFSR_CHK_ZERO_DETECT_EN rejects all-zero samples.
module lfsr_seq_checker #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned MISS_LIMIT = 3,
  parameter int unsigned COUNT_W    = 16
) (
  input  logic               clock,
  input  logic               reset_b,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               locked,
  output logic               err_pulse,
  output logic [COUNT_W-1:0] err_count,
  output logic [WIDTH-1:0]   expected
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_VERIFY,
    ST_LOCKED
  } state_t;

  // Feedback tap mask; bit n-1 is set for tap n, and the masks match the generator.
  function automatic logic [WIDTH-1:0] tap_mask();
    case (WIDTH)
      3:       return WIDTH'(9'b0_0000_0110);
      4:       return WIDTH'(9'b0_0000_1100);
      5:       return WIDTH'(9'b0_0001_0100);
      6:       return WIDTH'(9'b0_0011_0000);
      7:       return WIDTH'(9'b0_0110_0000);
      8:       return WIDTH'(9'b0_1011_1000);
      9:       return WIDTH'(9'b1_0001_0000);
      default: return WIDTH'(9'b0_0000_0000);
    endcase
  endfunction

  localparam logic [WIDTH-1:0] TAPS = tap_mask();

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  state_t           state;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] miss_cnt;

  logic             zero_s;
  logic             hit;
  logic             miss_evt;
  logic [CNT_W:0]   match_inc;
  logic [CNT_W:0]   miss_inc;

`ifdef LFSR_CHK_ZERO_DETECT_EN
  assign zero_s = ~|in_data;
`else
  assign zero_s = 1'b0;
`endif

  // An all-zero sample never counts as a hit when zero detection is enabled.
  assign hit       = (in_data == expected) && !zero_s;
  assign miss_evt  = (state == ST_LOCKED) && in_valid && !hit;
  assign match_inc = {1'b0, match_cnt} + (CNT_W+1)'(1);
  assign miss_inc  = {1'b0, miss_cnt} + (CNT_W+1)'(1);

  // Sync/lock state machine with its registered outputs.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state     <= ST_HUNT;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      expected  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        ST_HUNT: begin
          if (in_valid && !zero_s) begin
            expected  <= lfsr_next(in_data);
            match_cnt <= '0;
            state     <= ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (in_valid) begin
            if (zero_s) begin
              match_cnt <= '0;
              state     <= ST_HUNT;
            end else if (hit) begin
              expected  <= lfsr_next(in_data);
              match_cnt <= CNT_W'(match_inc);
              if (match_inc == (CNT_W+1)'(LOCK_CNT)) begin
                state    <= ST_LOCKED;
                locked   <= 1'b1;
                miss_cnt <= '0;
              end
            end else begin
              expected  <= lfsr_next(in_data);
              match_cnt <= '0;
            end
          end
        end
        ST_LOCKED: begin
          if (in_valid) begin
            if (hit) begin
              expected <= lfsr_next(in_data);
              miss_cnt <= '0;
            end else begin
              // Flywheel: advance our own prediction instead of trusting the bad sample.
              expected  <= lfsr_next(expected);
              err_pulse <= 1'b1;
              miss_cnt  <= CNT_W'(miss_inc);
              if (miss_inc == (CNT_W+1)'(MISS_LIMIT)) begin
                state  <= ST_HUNT;
                locked <= 1'b0;
              end
            end
          end
        end
        default: begin
          state  <= ST_HUNT;
          locked <= 1'b0;
        end
      endcase
    end
  end

  // Saturating error counter; clear takes priority over a same-cycle increment.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      err_count <= '0;
    end else if (clear) begin
      err_count <= '0;
    end else if (miss_evt && !(&err_count)) begin
      err_count <= err_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed self-checking bench for lfsr_seq_checker (WIDTH=4, taps 4,3).
// A second instance with COUNT_W=2, MISS_LIMIT=8 covers counter saturation.
module tb_lfsr_seq_checker;

  logic        clock;
  logic        reset_b;
  logic        clear;
  logic        in_valid;
  logic [3:0]  in_data;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [3:0]  expected;

  logic        clear2;
  logic        in_valid2;
  logic [3:0]  in_data2;
  logic        locked2;
  logic        err_pulse2;
  logic [1:0]  err_count2;
  logic [3:0]  expected2;

  int n_cmp;
  int n_bad;

  lfsr_seq_checker #(.WIDTH(4), .LOCK_CNT(4), .MISS_LIMIT(3), .COUNT_W(16)) dut (
    .clock(clock), .reset_b(reset_b), .clear(clear), .in_valid(in_valid),
    .in_data(in_data), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .expected(expected)
  );

  lfsr_seq_checker #(.WIDTH(4), .LOCK_CNT(4), .MISS_LIMIT(8), .COUNT_W(2)) dut2 (
    .clock(clock), .reset_b(reset_b), .clear(clear2), .in_valid(in_valid2),
    .in_data(in_data2), .locked(locked2), .err_pulse(err_pulse2),
    .err_count(err_count2), .expected(expected2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock with the given inputs on dut; returns 1 time unit after the edge.
  task automatic step(input logic v, input logic [3:0] d, input logic c);
    in_valid = v;
    in_data  = d;
    clear    = c;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic step2(input logic v, input logic [3:0] d);
    in_valid2 = v;
    in_data2  = d;
    @(posedge clock);
    #1;
    in_valid2 = 1'b0;
  endtask

  task automatic do_reset();
    reset_b = 1'b0;
    @(posedge clock);
    #1;
    reset_b = 1'b1;
  endtask

  task automatic test_reset();
    reset_b = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %0b want 0", locked); end
    n_cmp++;
    if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_err_pulse: got %0b want 0", err_pulse); end
    n_cmp++;
    if (err_count !== 16'd0) begin n_bad++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
    n_cmp++;
    if (expected !== 4'b0000) begin n_bad++; $display("FAIL reset_expected: got %b want 0000", expected); end
    reset_b = 1'b1;
  endtask

  task automatic test_sync();
    logic [3:0] seq [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, seq[i], 1'b0);
      n_cmp++;
      if (locked !== 1'b0) begin n_bad++; $display("FAIL sync_early_lock[%0d]: got %0b want 0", i, locked); end
    end
    n_cmp++;
    if (expected !== 4'b0011) begin n_bad++; $display("FAIL sync_predict: got %b want 0011", expected); end
    step(1'b1, seq[4], 1'b0);
    n_cmp++;
    if (locked !== 1'b1) begin n_bad++; $display("FAIL sync_locked: got %0b want 1", locked); end
    n_cmp++;
    if (err_count !== 16'd0) begin n_bad++; $display("FAIL sync_err_count: got %0d want 0", err_count); end
    n_cmp++;
    if (expected !== 4'b0110) begin n_bad++; $display("FAIL sync_expected: got %b want 0110", expected); end
  endtask

  task automatic test_single_error();
    step(1'b1, 4'b1111, 1'b0);
    n_cmp++;
    if (err_pulse !== 1'b1) begin n_bad++; $display("FAIL single_pulse: got %0b want 1", err_pulse); end
    n_cmp++;
    if (err_count !== 16'd1) begin n_bad++; $display("FAIL single_count: got %0d want 1", err_count); end
    n_cmp++;
    if (expected !== 4'b1101) begin n_bad++; $display("FAIL single_flywheel: got %b want 1101", expected); end
    step(1'b1, 4'b1101, 1'b0);
    n_cmp++;
    if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL single_pulse_drop: got %0b want 0", err_pulse); end
    n_cmp++;
    if (expected !== 4'b1010) begin n_bad++; $display("FAIL single_expected2: got %b want 1010", expected); end
    step(1'b1, 4'b1010, 1'b0);
    n_cmp++;
    if (err_count !== 16'd1) begin n_bad++; $display("FAIL single_count_hold: got %0d want 1", err_count); end
    n_cmp++;
    if (locked !== 1'b1) begin n_bad++; $display("FAIL single_locked: got %0b want 1", locked); end
    n_cmp++;
    if (expected !== 4'b0101) begin n_bad++; $display("FAIL single_expected3: got %b want 0101", expected); end
  endtask

  task automatic test_loss();
    step(1'b0, 4'b0000, 1'b1);
    n_cmp++;
    if (err_count !== 16'd0) begin n_bad++; $display("FAIL loss_clear: got %0d want 0", err_count); end
    // Predictions run 0101, 1011, 0111; 1111 misses all three.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 4'b1111, 1'b0);
      n_cmp++;
      if (locked !== 1'b1) begin n_bad++; $display("FAIL loss_held[%0d]: got %0b want 1", i, locked); end
    end
    step(1'b1, 4'b1111, 1'b0);
    n_cmp++;
    if (locked !== 1'b0) begin n_bad++; $display("FAIL loss_unlock: got %0b want 0", locked); end
    n_cmp++;
    if (err_count !== 16'd3) begin n_bad++; $display("FAIL loss_count: got %0d want 3", err_count); end
    n_cmp++;
    if (err_pulse !== 1'b1) begin n_bad++; $display("FAIL loss_pulse: got %0b want 1", err_pulse); end
    n_cmp++;
    if (expected !== 4'b1111) begin n_bad++; $display("FAIL loss_expected: got %b want 1111", expected); end
    step(1'b1, 4'b0001, 1'b0);
    n_cmp++;
    if (expected !== 4'b0010) begin n_bad++; $display("FAIL loss_reseed: got %b want 0010", expected); end
    n_cmp++;
    if (err_count !== 16'd3) begin n_bad++; $display("FAIL loss_hunt_count: got %0d want 3", err_count); end
  endtask

  task automatic test_gaps_clear();
    logic [3:0] seq [5];
    logic [3:0] nxt [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011};
    nxt = '{4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, seq[i], 1'b0);
      step(1'b0, 4'b1111, 1'b0);
      n_cmp++;
      if (expected !== nxt[i]) begin n_bad++; $display("FAIL gap_expected[%0d]: got %b want %b", i, expected, nxt[i]); end
      n_cmp++;
      if (locked !== (i == 4)) begin n_bad++; $display("FAIL gap_locked[%0d]: got %0b want %0b", i, locked, (i == 4)); end
    end
    step(1'b1, 4'b1111, 1'b1);
    n_cmp++;
    if (err_pulse !== 1'b1) begin n_bad++; $display("FAIL clear_pulse: got %0b want 1", err_pulse); end
    n_cmp++;
    if (err_count !== 16'd0) begin n_bad++; $display("FAIL clear_wins: got %0d want 0", err_count); end
    n_cmp++;
    if (locked !== 1'b1) begin n_bad++; $display("FAIL clear_locked: got %0b want 1", locked); end
    step(1'b1, 4'b1111, 1'b0);
    n_cmp++;
    if (err_count !== 16'd1) begin n_bad++; $display("FAIL clear_then_count: got %0d want 1", err_count); end
  endtask

  task automatic test_saturation_reset();
    logic [3:0] seq [5];
    logic [1:0] want;
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011};
    do_reset();
    for (int i = 0; i < 5; i++) step2(1'b1, seq[i]);
    n_cmp++;
    if (locked2 !== 1'b1) begin n_bad++; $display("FAIL sat_locked: got %0b want 1", locked2); end
    for (int i = 1; i <= 5; i++) begin
      step2(1'b1, 4'b1111);
      want = (i >= 3) ? 2'd3 : 2'(i);
      n_cmp++;
      if (err_count2 !== want) begin n_bad++; $display("FAIL sat_count[%0d]: got %0d want %0d", i, err_count2, want); end
    end
    n_cmp++;
    if (locked2 !== 1'b1) begin n_bad++; $display("FAIL sat_still_locked: got %0b want 1", locked2); end
    n_cmp++;
    if (expected2 !== 4'b0111) begin n_bad++; $display("FAIL sat_expected: got %b want 0111", expected2); end
    in_valid2 = 1'b1;
    in_data2  = 4'b1111;
    #2;
    reset_b = 1'b0;
    #1;
    n_cmp++;
    if (locked2 !== 1'b0) begin n_bad++; $display("FAIL async_locked: got %0b want 0", locked2); end
    n_cmp++;
    if (err_pulse2 !== 1'b0) begin n_bad++; $display("FAIL async_pulse: got %0b want 0", err_pulse2); end
    n_cmp++;
    if (err_count2 !== 2'd0) begin n_bad++; $display("FAIL async_count: got %0d want 0", err_count2); end
    n_cmp++;
    if (expected2 !== 4'b0000) begin n_bad++; $display("FAIL async_expected: got %b want 0000", expected2); end
    in_valid2 = 1'b0;
    @(posedge clock);
    #1;
    reset_b = 1'b1;
  endtask

  task automatic test_zero();
    do_reset();
`ifdef LFSR_CHK_ZERO_DETECT_EN
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 4'b0000, 1'b0);
      n_cmp++;
      if (locked !== 1'b0) begin n_bad++; $display("FAIL zero_det_locked[%0d]: got %0b want 0", i, locked); end
    end
    n_cmp++;
    if (expected !== 4'b0000) begin n_bad++; $display("FAIL zero_det_expected: got %b want 0000", expected); end
    step(1'b1, 4'b0001, 1'b0);
    n_cmp++;
    if (expected !== 4'b0010) begin n_bad++; $display("FAIL zero_det_seed: got %b want 0010", expected); end
`else
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'b0000, 1'b0);
      n_cmp++;
      if (locked !== 1'b0) begin n_bad++; $display("FAIL zero_early[%0d]: got %0b want 0", i, locked); end
    end
    step(1'b1, 4'b0000, 1'b0);
    n_cmp++;
    if (locked !== 1'b1) begin n_bad++; $display("FAIL zero_lock: got %0b want 1", locked); end
    n_cmp++;
    if (expected !== 4'b0000) begin n_bad++; $display("FAIL zero_expected: got %b want 0000", expected); end
`endif
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    reset_b   = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'b0000;
    clear2    = 1'b0;
    in_valid2 = 1'b0;
    in_data2  = 4'b0000;
    test_reset();
    test_sync();
    test_single_error();
    test_loss();
    test_gaps_clear();
    test_saturation_reset();
    test_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
